// File: rtl/fifo_drain_ctrl.sv
// fifo_drain_ctrl: FIFO read scheduler feeding UART TX with size-limited, gap-separated bursts.
// Define FIFO_DRAIN_TIMEOUT_EN to also start a partial drain after TIMEOUT_CYCLES of non-empty idle.
module fifo_drain_ctrl #(
    parameter int MAX_BURST      = 4,
    parameter int GAP_CYCLES     = 3,
    parameter int TIMEOUT_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        flush_req,
    input  logic        fifo_empty,
    input  logic        fifo_threshold,
    input  logic [7:0]  fifo_dout,
    output logic        fifo_rd,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic [15:0] bytes_sent
);
    typedef enum logic [1:0] {IDLE, FETCH, SEND, GAP} state_t;
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
    localparam state_t END_ST = GAP_CYCLES == 0 ? IDLE : GAP;
    if (MAX_BURST < 1 || TIMEOUT_CYCLES < 1 || GAP_CYCLES < 0) begin : g_bad_param
        $error("fifo_drain_ctrl: invalid parameters");
    end
    state_t state, state_nx;
    logic [BW-1:0] burst_cnt;
    logic [GW-1:0] gap_cnt;
    logic flush_pend, flush_mode, start, accept, last, gap_done, tmo_hit;
`ifdef FIFO_DRAIN_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;
    assign tmo_hit = tmo_cnt == TW'(TIMEOUT_CYCLES - 1);
    // Saturates at the hit value so a disabled controller cannot wrap past it.
    always_ff @(posedge clk) begin
        if (!rst_n || state != IDLE || start || fifo_empty) tmo_cnt <= '0;
        else if (!tmo_hit) tmo_cnt <= tmo_cnt + 1'b1;
    end
`else
    assign tmo_hit = 1'b0;
`endif
    assign start    = state == IDLE && en && !fifo_empty && (fifo_threshold || flush_pend || tmo_hit);
    assign accept   = state == SEND && tx_ready;
    assign last     = !en || (!flush_mode && int'(burst_cnt) + 1 == MAX_BURST);
    assign gap_done = int'(gap_cnt) == GAP_CYCLES - 1;
    assign fifo_rd  = state == FETCH && !fifo_empty;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? FETCH : IDLE;
            FETCH:   state_nx = !fifo_empty ? SEND : (burst_cnt != '0 ? END_ST : IDLE);
            SEND:    state_nx = !tx_ready ? SEND : (last ? END_ST : FETCH);
            GAP:     state_nx = gap_done ? IDLE : GAP;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            tx_valid   <= 1'b0;
            tx_data    <= 8'h00;
            busy       <= 1'b0;
            bytes_sent <= 16'h0000;
            burst_cnt  <= '0;
            gap_cnt    <= '0;
            flush_pend <= 1'b0;
            flush_mode <= 1'b0;
        end else begin
            state      <= state_nx;
            tx_valid   <= state_nx == SEND;
            busy       <= state_nx != IDLE;
            flush_pend <= flush_req || (flush_pend && !start);
            gap_cnt    <= state == GAP ? gap_cnt + 1'b1 : '0;
            if (start) begin
                burst_cnt  <= '0;
                flush_mode <= flush_pend;
            end else if (accept && burst_cnt != '1) begin
                burst_cnt <= burst_cnt + 1'b1;
            end
            if (fifo_rd) tx_data <= fifo_dout;
            if (accept) bytes_sent <= bytes_sent + 1'b1;
        end
    end
endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// tb_fifo_drain_ctrl: directed bench with a small FIFO model and TX monitor.
module tb_fifo_drain_ctrl;
    logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, flush_req = 1'b0, tx_ready = 1'b0;
    logic fifo_empty, fifo_threshold, fifo_rd, tx_valid, busy;
    logic [7:0] fifo_dout, tx_data;
    logic [15:0] bytes_sent;
    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    fifo_drain_ctrl dut (
        .clk(clk), .rst_n(rst_n), .en(en), .flush_req(flush_req),
        .fifo_empty(fifo_empty), .fifo_threshold(fifo_threshold), .fifo_dout(fifo_dout),
        .fifo_rd(fifo_rd), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .bytes_sent(bytes_sent)
    );

    // FIFO model: threshold at 4 entries, show-ahead output
    logic [7:0] mem [16];
    logic [3:0] wp = 4'd0, rp = 4'd0;
    int cnt = 0;
    logic push = 1'b0;
    logic [7:0] push_d = 8'h00;
    always @(posedge clk) begin
        if (push) begin
            mem[wp] <= push_d;
            wp <= wp + 4'd1;
        end
        if (fifo_rd && cnt > 0) rp <= rp + 4'd1;
        cnt <= cnt + int'(push) - int'(fifo_rd && cnt > 0);
    end
    assign fifo_empty     = cnt == 0;
    assign fifo_threshold = cnt >= 4;
    assign fifo_dout      = mem[rp];

    // TX monitor: records accepted bytes with the cycle they were accepted on
    int cyc = 0, rx_n = 0, rd_empty = 0;
    logic [7:0] rx_d [64];
    int rx_c [64];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && tx_valid && tx_ready && rx_n < 64) begin
            rx_d[rx_n] <= tx_data;
            rx_c[rx_n] <= cyc;
            rx_n <= rx_n + 1;
        end
        if (fifo_rd && fifo_empty) rd_empty <= rd_empty + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] d);
        push = 1'b1;
        push_d = d;
        tick();
        push = 1'b0;
    endtask

    task automatic pulse_flush();
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
    endtask

    task automatic wait_rx(input int target);
        for (int i = 0; i < 300 && rx_n < target; i++) tick();
        chk("rx_count", rx_n, target);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300 && (busy || !fifo_empty); i++) tick();
        chk("idle_reached", {30'd0, busy, fifo_empty}, 32'd1);
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 300 && !tx_valid; i++) tick();
        chk("valid_reached", tx_valid, 1);
    endtask

    initial begin
        int b, hits, seen_rd, seen_v, bad_hold, rd_cnt;
        logic [7:0] vd;
        // 1: reset
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_fifo_rd", fifo_rd, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_bytes_sent", bytes_sent, 0);
        hits = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            hits += int'(busy);
        end
        chk("idle_busy_cycles", hits, 0);
        // 2: threshold bursts of MAX_BURST separated by a 3-cycle gap
        tx_ready = 1'b1;
        for (int i = 1; i <= 8; i++) push_byte(8'(i));
        b = rx_n;
        en = 1'b1;
        wait_rx(b + 8);
        wait_idle();
        for (int i = 0; i < 8; i++) chk($sformatf("t2_data%0d", i), rx_d[b + i], i + 1);
        for (int i = 1; i < 8; i++) chk($sformatf("t2_spacing%0d", i), rx_c[b + i] - rx_c[b + i - 1], i == 4 ? 6 : 2);
        chk("t2_bytes_sent", bytes_sent, 8);
        // 3: single byte, timeout drain
        b = rx_n;
        push_byte(8'hA5);
`ifdef FIFO_DRAIN_TIMEOUT_EN
        seen_rd = -1;
        seen_v = -1;
        vd = 8'h00;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (fifo_rd && seen_rd < 0) seen_rd = k;
            if (tx_valid && seen_v < 0) begin
                seen_v = k;
                vd = tx_data;
            end
        end
        chk("t3_rd_latency", seen_rd, 8);
        chk("t3_valid_latency", seen_v, 9);
        chk("t3_valid_data", vd, 8'hA5);
`else
        hits = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            hits += int'(tx_valid) + int'(fifo_rd);
        end
        chk("t3_no_timeout", hits, 0);
        pulse_flush();
`endif
        wait_rx(b + 1);
        wait_idle();
        chk("t3_data", rx_d[b], 8'hA5);
        chk("t3_bytes_sent", bytes_sent, 9);
        // 4: backpressure holds data
        tx_ready = 1'b0;
        b = rx_n;
        push_byte(8'h11);
        push_byte(8'h12);
        pulse_flush();
        wait_valid();
        chk("t4_first_data", tx_data, 8'h11);
        hits = 0;
        bad_hold = 0;
        rd_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            hits += int'(tx_valid);
            bad_hold += int'(tx_data !== 8'h11);
            rd_cnt += int'(fifo_rd);
        end
        chk("t4_valid_held", hits, 5);
        chk("t4_data_changes", bad_hold, 0);
        chk("t4_no_pop", rd_cnt, 0);
        tx_ready = 1'b1;
        wait_rx(b + 2);
        wait_idle();
        chk("t4_data0", rx_d[b], 8'h11);
        chk("t4_data1", rx_d[b + 1], 8'h12);
        chk("t4_bytes_sent", bytes_sent, 11);
        // 5: flush drains everything in one burst
        en = 1'b0;
        b = rx_n;
        for (int i = 0; i < 6; i++) push_byte(8'h20 + 8'(i));
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        en = 1'b1;
        wait_rx(b + 6);
        tick();
        tick();
        tick();
        chk("t5_busy_in_gap", busy, 1);
        tick();
        chk("t5_busy_after_gap", busy, 0);
        for (int i = 0; i < 6; i++) chk($sformatf("t5_data%0d", i), rx_d[b + i], 8'h20 + i);
        for (int i = 1; i < 6; i++) chk($sformatf("t5_spacing%0d", i), rx_c[b + i] - rx_c[b + i - 1], 2);
        chk("t5_bytes_sent", bytes_sent, 17);
        // 6: reset during SEND discards the held byte
        tx_ready = 1'b0;
        b = rx_n;
        push_byte(8'h33);
        pulse_flush();
        wait_valid();
        chk("t6_held_data", tx_data, 8'h33);
        rst_n = 1'b0;
        tick();
        chk("t6_rst_tx_valid", tx_valid, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_bytes_sent", bytes_sent, 0);
        rst_n = 1'b1;
        tx_ready = 1'b1;
        hits = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            hits += int'(tx_valid);
        end
        chk("t6_no_valid_after_rst", hits, 0);
        chk("t6_no_accept", rx_n, b);
        chk("rd_while_empty", rd_empty, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
